// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle unsigned adder/subtractor that processes DIGIT bits per clock,
//   LSB first. A whole operation takes WIDTH/DIGIT cycles. Each operation is
//   requested through a start/busy/done handshake.
//
//   Optional feature: define SERIAL_ADDSUB_OVF_EN to enable signed overflow
//   detection on ovf. Without it, ovf is tied to 0.
//
// Parameters
//   WIDTH : operand/result width in bits (>= 2)
//   DIGIT : bits processed per cycle (must divide WIDTH)
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : operation request, sampled only while idle
//   a, b  : unsigned operands
//   m     : 0 = add (a+b), 1 = subtract (a-b)
//   busy  : operation in progress
//   done  : one-cycle pulse when SD/CoBo/ovf have just been written
//   CoBo  : carry-out for add, borrow (a < b) for subtract
//   SD    : sum/difference modulo 2^WIDTH
//   ovf   : signed two's-complement overflow (0 unless feature enabled)
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic             CoBo,
    output logic [WIDTH-1:0] SD,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] opa, opb, res, res_next;
    logic [CW-1:0]    cnt;
    logic             carry, mode;
    logic [DIGIT:0]   dsum;
    logic             accept, last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One digit of the ripple: low DIGIT bits of each operand plus carry.
    // The new sum digit enters the result register from the top, so after
    // N shifts the first (least significant) digit has reached bit 0.
    always_comb begin
        dsum     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};
        res_next = WIDTH'({dsum[DIGIT-1:0], res} >> DIGIT);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            mode  <= 1'b0;
            done  <= 1'b0;
            CoBo  <= 1'b0;
            SD    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Subtraction is a + ~b + 1: invert b and seed carry with 1.
                opa   <= a;
                opb   <= m ? ~b : b;
                carry <= m;
                mode  <= m;
                cnt   <= '0;
            end else if (state == RUN) begin
                opa   <= opa >> DIGIT;
                opb   <= opb >> DIGIT;
                res   <= res_next;
                carry <= dsum[DIGIT];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    SD   <= res_next;
                    // Raw carry-out of a + ~b + 1 is the inverse of a borrow.
                    CoBo <= dsum[DIGIT] ^ mode;
                    done <= 1'b1;
                    cnt  <= '0;
                end
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic sign_a, sign_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sign_a <= a[WIDTH-1];
            sign_b <= m ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (last) begin
            ovf <= (sign_a == sign_b) && (res_next[WIDTH-1] != sign_a);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub. Two instances are exercised:
//   u_d1 (WIDTH=6, DIGIT=1) and u_d2 (WIDTH=6, DIGIT=2). Expected results are
//   pushed to a scoreboard queue when an operation is started and popped when
//   done pulses.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start1 = 1'b0, m1 = 1'b0;
    logic [5:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cobo1, ovf1;
    logic [5:0] sd1;

    logic       start2 = 1'b0, m2 = 1'b0;
    logic [5:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cobo2, ovf2;
    logic [5:0] sd2;

    serial_addsub #(.WIDTH(6), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .m(m1),
        .busy(busy1), .done(done1), .CoBo(cobo1), .SD(sd1), .ovf(ovf1)
    );

    serial_addsub #(.WIDTH(6), .DIGIT(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .m(m2),
        .busy(busy2), .done(done2), .CoBo(cobo2), .SD(sd2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       cobo;
        logic       ovf;
        logic [5:0] sd;
    } outs_t;

    typedef struct packed {
        logic [5:0] sd;
        logic       cobo;
        logic       ovf;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle    = 0;
    int         acc_cycle[1:2];
    logic [5:0] prev_sd[1:2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic outs_t outs(input int sel);
        outs_t o;
        if (sel == 1) o = '{busy1, done1, cobo1, ovf1, sd1};
        else          o = '{busy2, done2, cobo2, ovf2, sd2};
        return o;
    endfunction

    task automatic drive(input int sel, input logic s, input logic [5:0] aa,
                         input logic [5:0] bb, input logic mm);
        if (sel == 1) begin start1 = s; a1 = aa; b1 = bb; m1 = mm; end
        else          begin start2 = s; a2 = aa; b2 = bb; m2 = mm; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Reference: plain integer arithmetic, independent of the digit-serial form.
    task automatic push_exp(input logic [5:0] aa, input logic [5:0] bb, input logic mm);
        exp_t e;
        int   sa, sb, r;
        if (mm) begin
            e.sd   = aa - bb;
            e.cobo = (aa < bb);
        end else begin
            {e.cobo, e.sd} = {1'b0, aa} + {1'b0, bb};
        end
        sa = aa[5] ? int'(aa) - 64 : int'(aa);
        sb = bb[5] ? int'(bb) - 64 : int'(bb);
        r  = mm ? sa - sb : sa + sb;
`ifdef SERIAL_ADDSUB_OVF_EN
        e.ovf = (r > 31) || (r < -32);
`else
        e.ovf = (r > 1000);
`endif
        exp_q.push_back(e);
    endtask

    task automatic start_op(input int sel, input logic [5:0] aa, input logic [5:0] bb,
                            input logic mm);
        outs_t o;
        drive(sel, 1'b1, aa, bb, mm);
        push_exp(aa, bb, mm);
        step();
        acc_cycle[sel] = cycle;
        drive(sel, 1'b0, aa, bb, mm);
        o = outs(sel);
        check("accept_busy", o.busy, 1);
    endtask

    task automatic finish_op(input int sel, input int n);
        outs_t o;
        exp_t  e;
        o = outs(sel);
        while (!o.done && (cycle - acc_cycle[sel]) < n + 4) begin
            check("sd_hold", o.sd, prev_sd[sel]);
            step();
            o = outs(sel);
        end
        check("done_seen", o.done, 1);
        check("latency", cycle - acc_cycle[sel], n);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check("sd", o.sd, e.sd);
            check("cobo", o.cobo, e.cobo);
            check("ovf", o.ovf, e.ovf);
            check("busy_at_done", o.busy, 0);
            prev_sd[sel] = e.sd;
        end
    endtask

    task automatic check_reset_outs(input int sel);
        outs_t o;
        o = outs(sel);
        check("rst_busy", o.busy, 0);
        check("rst_done", o.done, 0);
        check("rst_sd",   o.sd,   0);
        check("rst_cobo", o.cobo, 0);
        check("rst_ovf",  o.ovf,  0);
    endtask

    initial begin
        outs_t o;
        prev_sd[1] = '0;
        prev_sd[2] = '0;
        acc_cycle[1] = 0;
        acc_cycle[2] = 0;

        // Reset state
        step();
        step();
        check_reset_outs(1);
        check_reset_outs(2);
        rst = 1'b0;
        step();

        // DIGIT=1 add
        start_op(1, 6'd23, 6'd20, 1'b0);
        finish_op(1, 6);
        start_op(1, 6'd30, 6'd63, 1'b0);
        finish_op(1, 6);

        // DIGIT=1 subtract
        start_op(1, 6'd53, 6'd10, 1'b1);
        finish_op(1, 6);
        start_op(1, 6'd23, 6'd40, 1'b1);
        finish_op(1, 6);
        start_op(1, 6'd12, 6'd6, 1'b1);
        finish_op(1, 6);

        // done pulse lasts exactly one cycle
        step();
        o = outs(1);
        check("done_one_cycle", o.done, 0);

        // start pulses while busy with different operands must be ignored
        start_op(1, 6'd45, 6'd7, 1'b0);
        step();
        drive(1, 1'b1, 6'd5, 6'd9, 1'b1);
        step();
        o = outs(1);
        check("ignored_sd_hold", o.sd, prev_sd[1]);
        drive(1, 1'b0, 6'd1, 6'd2, 1'b1);
        finish_op(1, 6);

        // asynchronous reset in cycle 3 of 6 aborts the operation
        start_op(1, 6'd33, 6'd11, 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        check_reset_outs(1);
        exp_q.delete();
        prev_sd[1] = '0;
        step();
        rst = 1'b0;
        step();
        start_op(1, 6'd2, 6'd56, 1'b0);
        finish_op(1, 6);

        // DIGIT=2, then back-to-back start in the done cycle
        start_op(2, 6'd56, 6'd42, 1'b0);
        finish_op(2, 3);
        start_op(2, 6'd15, 6'd60, 1'b1);
        finish_op(2, 3);

        // Overflow cases (ovf expected 0 unless the feature is compiled in)
        start_op(1, 6'd30, 6'd20, 1'b0);
        finish_op(1, 6);
        start_op(1, 6'd23, 6'd10, 1'b1);
        finish_op(1, 6);

        // A few random operations on both instances, back-to-back
        for (int i = 0; i < 6; i++) begin
            start_op(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)));
            finish_op(1, 6);
            start_op(2, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)));
            finish_op(2, 3);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It processes DIGIT bits per clock, LSB first, over WIDTH/DIGIT cycles, and uses a start/busy/done handshake. It is the sequential, width-generalised successor of the team's 6-bit dataflow adder/subtractor and keeps the same a/b/m/CoBo/SD semantics. It sits in datapaths where area matters more than single-cycle latency.

Parameters:
- WIDTH, 6, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only while idle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- m  input  1  mode: 0 = add (a+b), 1 = subtract (a−b)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result has just been written
- CoBo  output  1  add: carry-out; subtract: borrow (1 iff a < b unsigned)
- SD  output  WIDTH  sum/difference, modulo 2^WIDTH
- ovf  output  1  signed two's-complement overflow (see Optional Feature)

Behaviour:
- Reset values: busy=0, done=0, CoBo=0, SD=0, ovf=0; FSM state IDLE; digit counter 0; internal operand, result and carry registers 0.
- Latency: N = WIDTH/DIGIT cycles.
- FSM states: IDLE and RUN.
- IDLE:
  - On a clk edge with start=1, the block latches a, b and m.
  - It loads the operand shift registers with a and (m ? ~b : b).
  - It sets the internal carry to m and the counter to 0.
  - It moves to RUN and drives busy=1 from that edge.
- RUN, each edge:
  - Adds the low DIGIT bits of both shift registers plus carry.
  - Shifts the DIGIT sum bits into the result register from the top.
  - Updates the carry, shifts both operands right by DIGIT, and increments the counter.
- On the edge that processes digit N−1:
  - SD ← full result; raw carry-out c is formed.
  - CoBo ← c when m=0, ~c when m=1.
  - ovf is updated.
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- For start accepted at edge k, the result is visible after edge k+N.
- SD, CoBo and ovf hold their previous values throughout RUN and change only on the completing edge.
- start while busy=1 is ignored; there is no queueing.
- start=1 in the cycle where done=1 is accepted, so operations can run back-to-back with no idle gap.
- Changes to a, b or m after acceptance do not affect the running operation.
- Reset mid-operation aborts it: all outputs return to their reset values asynchronously, and the next start after rst deasserts begins normally.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Subtraction is a + ~b + 1 at WIDTH bits.
  - CoBo matches {CoBo,SD} = a+b for add, and indicates a borrow for subtract.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN.
- Defined:
  - The block keeps the sign bits of the operands (a and the possibly inverted b).
  - On the completing edge, ovf ← 1 iff both operand signs are equal and differ from SD[WIDTH−1].
  - ovf is updated together with SD.
- Undefined: ovf is constant 0 and the sign-capture logic is omitted. The port list is unchanged.

Test Plan:
- WIDTH=6, DIGIT=1, start with a=23, b=20, m=0 → busy high 6 cycles, then done pulse; SD=43, CoBo=0. Then a=30, b=63, m=0 → SD=29, CoBo=1.
- WIDTH=6, DIGIT=1, subtract cases:
  - a=53, b=10, m=1 → SD=43, CoBo=0.
  - a=23, b=40, m=1 → SD=47, CoBo=1.
  - a=12, b=6, m=1 → SD=6, CoBo=0.
- WIDTH=6, DIGIT=2, a=56, b=42, m=0 → done exactly 3 cycles after start; SD=34, CoBo=1. Then start asserted in the done cycle with a=15, b=60, m=1 → accepted immediately; SD=19, CoBo=1 after 3 more cycles.
- Start pulses during busy, with changed a/b/m → ignored; result reflects the original operands; SD unchanged until the completing edge.
- rst asserted mid-operation (cycle 3 of 6) → busy, done, SD, CoBo and ovf go to 0 asynchronously. The next start with a=2, b=56, m=0 → SD=58, CoBo=0.
- With SERIAL_ADDSUB_OVF_EN, WIDTH=6:
  - a=30, b=20, m=0 → SD=50, ovf=1.
  - a=23, b=10, m=1 → ovf=0.
  - Without the macro, ovf stays 0 for both cases.
